btb: RTL and testbench



---
 rtl/btb.sv | 129 ++++++++++++
 tb/tb_btb.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/btb.sv
// Branch target buffer: fully associative, insertion-ordered table of taken branches.
// Lookup is combinational on the registered table; execute-stage updates land at the clock edge.
module btb #(
    parameter int TAG_SIZE    = 10,
    parameter int TARGET_SIZE = 12,
    parameter int BTB_ROW     = 10,
    parameter int PC_ALIAS    = 10
) (
    input  logic                                 clock,
    input  logic                                 reset,
    input  logic                                 enable,
    input  logic [31:0]                          current_pc,
    input  logic                                 if_branch,
    input  logic [31:0]                          ex_pc,
    input  logic [31:0]                          calculated_pc,
    input  logic                                 ex_branch_taken,
    input  logic                                 ex_en_branch,
    output logic [31:0]                          target_pc,
    output logic                                 valid_target,
    output logic [BTB_ROW-1:0]                   valid_out,
    output logic [$clog2(BTB_ROW):0]             BTB_count_out,
    output logic [BTB_ROW-1:0][TAG_SIZE-1:0]     tag_out,
    output logic [BTB_ROW-1:0][TARGET_SIZE-1:0]  target_address_out
);

    localparam int IW = $clog2(BTB_ROW);
    localparam int CW = IW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(BTB_ROW);
    localparam logic [CW-1:0] ONE        = CW'(1);

    logic [BTB_ROW-1:0]                  valid_q, valid_d;
    logic [CW-1:0]                       count_q, count_d;
    logic [BTB_ROW-1:0][TAG_SIZE-1:0]    tag_q, tag_d;
    logic [BTB_ROW-1:0][TARGET_SIZE-1:0] tgt_q, tgt_d;

    logic [TAG_SIZE-1:0]    ex_tag, lk_tag;
    logic [TARGET_SIZE-1:0] new_tgt;
    logic                   ex_hit, lk_hit;
    logic [IW-1:0]          ex_idx, lk_idx;
    logic                   unused_bits;

    assign ex_tag  = ex_pc[PC_ALIAS+TAG_SIZE-1:PC_ALIAS];
    assign lk_tag  = current_pc[PC_ALIAS+TAG_SIZE-1:PC_ALIAS];
    assign new_tgt = calculated_pc[TARGET_SIZE+1:2];
    assign unused_bits = ^{ex_pc, calculated_pc};

    // Descending scan so the lowest matching index is the one left standing.
    always_comb begin
        ex_hit = 1'b0;
        ex_idx = '0;
        lk_hit = 1'b0;
        lk_idx = '0;
        for (int i = BTB_ROW - 1; i >= 0; i--) begin
            if (valid_q[i] && tag_q[i] == ex_tag) begin
                ex_hit = 1'b1;
                ex_idx = IW'(i);
            end
            if (valid_q[i] && tag_q[i] == lk_tag) begin
                lk_hit = 1'b1;
                lk_idx = IW'(i);
            end
        end
    end

    always_comb begin
        valid_d = valid_q;
        count_d = count_q;
        tag_d   = tag_q;
        tgt_d   = tgt_q;
        if (enable && ex_en_branch) begin
            if (ex_branch_taken) begin
                if (ex_hit) begin
                    tgt_d[ex_idx] = new_tgt;
                end else if (count_q != FULL_COUNT) begin
                    valid_d[count_q[IW-1:0]] = 1'b1;
                    tag_d[count_q[IW-1:0]]   = ex_tag;
                    tgt_d[count_q[IW-1:0]]   = new_tgt;
                    count_d                  = count_q + ONE;
                end else begin
                    for (int i = 0; i < BTB_ROW - 1; i++) begin
                        valid_d[i] = valid_q[i+1];
                        tag_d[i]   = tag_q[i+1];
                        tgt_d[i]   = tgt_q[i+1];
                    end
                    valid_d[BTB_ROW-1] = 1'b1;
                    tag_d[BTB_ROW-1]   = ex_tag;
                    tgt_d[BTB_ROW-1]   = new_tgt;
                end
            end else if (ex_hit) begin
                // Close the gap left by the removed entry to keep the table compacted.
                for (int i = 0; i < BTB_ROW - 1; i++) begin
                    if (i >= int'(ex_idx)) begin
                        valid_d[i] = valid_q[i+1];
                        tag_d[i]   = tag_q[i+1];
                        tgt_d[i]   = tgt_q[i+1];
                    end
                end
                valid_d[BTB_ROW-1] = 1'b0;
                tag_d[BTB_ROW-1]   = '0;
                tgt_d[BTB_ROW-1]   = '0;
                count_d            = count_q - ONE;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            valid_q <= '0;
            count_q <= '0;
            tag_q   <= '0;
            tgt_q   <= '0;
        end else begin
            valid_q <= valid_d;
            count_q <= count_d;
            tag_q   <= tag_d;
            tgt_q   <= tgt_d;
        end
    end

    assign valid_target = enable & if_branch & lk_hit;
    assign target_pc    = valid_target ? {current_pc[31:TARGET_SIZE+2], tgt_q[lk_idx], 2'b00}
                                       : current_pc + 32'd4;

    assign valid_out          = valid_q;
    assign BTB_count_out      = count_q;
    assign tag_out            = tag_q;
    assign target_address_out = tgt_q;

endmodule

// File: tb/tb_btb.sv
// Bench for btb: driver pushes expectations from a queue-based table model,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_btb;

    localparam int TS  = 10;
    localparam int GS  = 12;
    localparam int ROW = 10;
    localparam int PA  = 10;
    localparam int CW  = $clog2(ROW) + 1;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic [31:0] current_pc = '0;
    logic        if_branch = 1'b0;
    logic [31:0] ex_pc = '0;
    logic [31:0] calculated_pc = '0;
    logic        ex_branch_taken = 1'b0;
    logic        ex_en_branch = 1'b0;
    logic [31:0] target_pc;
    logic        valid_target;
    logic [ROW-1:0]         valid_out;
    logic [CW-1:0]          BTB_count_out;
    logic [ROW-1:0][TS-1:0] tag_out;
    logic [ROW-1:0][GS-1:0] target_address_out;

    btb #(.TAG_SIZE(TS), .TARGET_SIZE(GS), .BTB_ROW(ROW), .PC_ALIAS(PA)) dut (
        .clock(clock), .reset(reset), .enable(enable),
        .current_pc(current_pc), .if_branch(if_branch),
        .ex_pc(ex_pc), .calculated_pc(calculated_pc),
        .ex_branch_taken(ex_branch_taken), .ex_en_branch(ex_en_branch),
        .target_pc(target_pc), .valid_target(valid_target),
        .valid_out(valid_out), .BTB_count_out(BTB_count_out),
        .tag_out(tag_out), .target_address_out(target_address_out)
    );

    typedef struct {
        logic [TS-1:0] tag;
        logic [GS-1:0] tgt;
    } ent_t;

    typedef struct {
        logic [31:0]            tpc;
        logic                   vt;
        logic [CW-1:0]          cnt;
        logic [ROW-1:0]         vld;
        logic [ROW-1:0][TS-1:0] tags;
        logic [ROW-1:0][GS-1:0] tgts;
    } exp_t;

    ent_t tbl[$];
    exp_t sb[$];
    int checks = 0;
    int passes = 0;

    function automatic int find(input logic [TS-1:0] t);
        for (int i = 0; i < tbl.size(); i++)
            if (tbl[i].tag == t) return i;
        return -1;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    always @(negedge clock) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            chk("target_pc",    128'(target_pc),          128'(e.tpc));
            chk("valid_target", 128'(valid_target),       128'(e.vt));
            chk("count",        128'(BTB_count_out),      128'(e.cnt));
            chk("valid_out",    128'(valid_out),          128'(e.vld));
            chk("tag_out",      128'(tag_out),            128'(e.tags));
            chk("target_out",   128'(target_address_out), 128'(e.tgts));
        end
    end

    task automatic cyc(input logic rst, input logic en, input logic ib, input logic [31:0] cpc,
                       input logic eb, input logic tk, input logic [31:0] epc, input logic [31:0] cal);
        int   idx;
        exp_t e;
        ent_t n;
        @(posedge clock);
        #1;
        reset = rst; enable = en; if_branch = ib; current_pc = cpc;
        ex_en_branch = eb; ex_branch_taken = tk; ex_pc = epc; calculated_pc = cal;
        if (!rst) begin
            idx  = find(cpc[PA+TS-1:PA]);
            e.vt = en && ib && (idx >= 0);
            e.tpc = e.vt ? ((cpc & ~((32'h1 << (GS + 2)) - 1)) | (32'(tbl[idx].tgt) << 2))
                         : cpc + 32'd4;
            e.cnt  = CW'(tbl.size());
            e.vld  = '0;
            e.tags = '0;
            e.tgts = '0;
            for (int i = 0; i < tbl.size(); i++) begin
                e.vld[i]  = 1'b1;
                e.tags[i] = tbl[i].tag;
                e.tgts[i] = tbl[i].tgt;
            end
            sb.push_back(e);
        end
        // Model state after the coming edge.
        if (rst) begin
            tbl.delete();
        end else if (en && eb) begin
            n.tag = epc[PA+TS-1:PA];
            n.tgt = cal[GS+1:2];
            idx   = find(n.tag);
            if (tk) begin
                if (idx >= 0) tbl[idx] = n;
                else begin
                    tbl.push_back(n);
                    if (tbl.size() > ROW) void'(tbl.pop_front());
                end
            end else if (idx >= 0) begin
                tbl.delete(idx);
            end
        end
    endtask

    task automatic idle(input logic [31:0] cpc, input logic ib);
        cyc(1'b0, 1'b1, ib, cpc, 1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic upd(input logic tk, input logic [31:0] epc, input logic [31:0] cal);
        cyc(1'b0, 1'b1, 1'b0, 32'h100, 1'b1, tk, epc, cal);
    endtask

    initial begin
        logic [31:0] pc2;
        int          wait_cycles;

        cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        cyc(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        idle(32'h4, 1'b1);

        upd(1'b1, 32'h4, 32'h8);
        idle(32'h4, 1'b1);
        idle(32'h4, 1'b0);

        for (int k = 1; k <= 11; k++)
            upd(1'b1, 32'h400 * k, 32'h1000 + 32'(k) * 32'h24);
        idle(32'h2C00, 1'b1);
        idle(32'h0004, 1'b1);

        pc2 = 32'(tbl[2].tag) << PA;
        upd(1'b0, pc2, 32'h0);
        idle(pc2, 1'b1);
        upd(1'b0, 32'h0000_0040, 32'h0);
        upd(1'b1, 32'h2C00, 32'h0000_3ABC);
        idle(32'h1234_6C08, 1'b1);

        // Same-cycle lookup and insert: lookup sees the old table.
        cyc(1'b0, 1'b1, 1'b1, 32'h5000, 1'b1, 1'b1, 32'h5000, 32'h5550);
        idle(32'h5000, 1'b1);

        // Enable low: strobe ignored, no prediction.
        cyc(1'b0, 1'b0, 1'b1, 32'h5000, 1'b1, 1'b0, 32'h5000, 32'h0);
        idle(32'h5000, 1'b1);

        // Reset wins over a simultaneous update.
        cyc(1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 32'h6000, 32'h6660);
        idle(32'h6000, 1'b1);

        for (int n = 0; n < 400; n++) begin
            logic [31:0] cpc, epc;
            cpc = ($urandom & 32'hFFF0_03FF) | (32'($urandom_range(0, 15)) << PA);
            epc = ($urandom & 32'hFFF0_03FF) | (32'($urandom_range(0, 15)) << PA);
            cyc(1'b0, $urandom_range(0, 7) != 0, 1'($urandom), cpc,
                $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0, epc, $urandom);
        end
        idle(32'h0, 1'b0);

        wait_cycles = 0;
        while (sb.size() > 0 && wait_cycles < 10) begin
            @(posedge clock);
            wait_cycles++;
        end
        if (sb.size() > 0) begin
            checks++;
            $display("FAIL drain: %0d expectations left, required 0", sb.size());
        end
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
